multi_lane_judge: RTL

- N-lane rhythm-game judging core; successor to the single-lane note datapath.
- Holds one note shift register per lane and scrolls all lanes on a rate tick.
- Judges edge-detected presses per lane and maintains a saturating score, current combo and best combo.
- Sits between the note rate divider (tick source) and the score display / VGA renderer (heads, hit/miss pulses).

---
 rtl/multi_lane_judge_pkg.sv | 28 ++
 rtl/multi_lane_judge_lane_slot.sv | 62 ++++++
 rtl/multi_lane_judge.sv | 137 +++++++++++++
 3 files changed

// File: rtl/multi_lane_judge_pkg.sv
// Shared types and helpers for the multi-lane judging core.
// Holds the FSM encoding, default sizes and a clamping adder.
package multi_lane_judge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_LANES = 4;
  localparam int DEF_DEPTH = 500;

  // base + delta clamped to [0, hi]
  function automatic int sat_add(
    input int base,
    input int delta,
    input int hi
  );
    int s;
    s = base + delta;
    if (s < 0) return 0;
    if (s > hi) return hi;
    return s;
  endfunction

endpackage

// File: rtl/multi_lane_judge_lane_slot.sv
// One note lane: shift register, judged flag, press edge detect.
// Ports: load/act/tick control, press level in; head, hit/miss/wrong strobes out.
import multi_lane_judge_pkg::*;

module lane_slot #(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             act,
  input  logic             tick,
  input  logic             press,
  input  logic [DEPTH-1:0] pattern,
  output logic             head,
  output logic             hit,
  output logic             miss,
  output logic             wrong
);

  logic [DEPTH-1:0] sr_q, sr_d;
  logic             judged_q, judged_d;
  logic             press_q, press_d;
  logic             edge_s;
  logic             live;

  assign head    = sr_q[0];
  assign press_d = press;
  assign edge_s  = press & ~press_q;
  assign live    = head & ~judged_q;
  assign hit     = act & edge_s & live;
  assign wrong   = act & edge_s & ~live;
  // a note hit in the same cycle as the tick is not a miss
  assign miss    = act & tick & live & ~edge_s;

  always_comb begin
    sr_d     = sr_q;
    judged_d = judged_q;
    if (load) begin
      sr_d     = pattern;
      judged_d = 1'b0;
    end else if (act && tick) begin
      sr_d     = {1'b0, sr_q[DEPTH-1:1]};
      judged_d = 1'b0;
    end else if (hit) begin
      judged_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q     <= '0;
      judged_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      judged_q <= judged_d;
      press_q  <= press_d;
    end
  end

endmodule

// File: rtl/multi_lane_judge.sv
// N-lane rhythm judge: FSM, tick counter, score and combo tracking.
// Ports: clk/reset/running/tick/pattern_in/press in; heads/hit/miss/score/combo/max_combo/done out.
import multi_lane_judge_pkg::*;

module multi_lane_judge #(
  parameter int LANES     = DEF_LANES,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int SCORE_W   = 10,
  parameter int MAX_SCORE = 999,
  parameter int PENALTY   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   running,
  input  logic                   tick,
  input  logic [LANES*DEPTH-1:0] pattern_in,
  input  logic [LANES-1:0]       press,
  output logic [LANES-1:0]       heads,
  output logic [LANES-1:0]       hit,
  output logic [LANES-1:0]       miss,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     combo,
  output logic [SCORE_W-1:0]     max_combo,
  output logic                   done
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int CMAX = (1 << SCORE_W) - 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   combo_q, combo_d;
  logic [SCORE_W-1:0]   max_q, max_d;
  logic [LANES-1:0]     hit_q, hit_d;
  logic [LANES-1:0]     miss_q, miss_d;
  logic [LANES-1:0]     hit_s, miss_s, wrong_s;
  logic                 load, act;
  int                   n_hit, n_wrong;

  assign load = (state_q == IDLE);
  assign act  = (state_q == RUN) && running;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_slot #(.DEPTH(DEPTH)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .act     (act),
      .tick    (tick),
      .press   (press[k]),
      .pattern (pattern_in[k*DEPTH +: DEPTH]),
      .head    (heads[k]),
      .hit     (hit_s[k]),
      .miss    (miss_s[k]),
      .wrong   (wrong_s[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;
    hit_d   = '0;
    miss_d  = '0;
    n_hit   = 0;
    n_wrong = 0;
    for (int k = 0; k < LANES; k++) begin
      n_hit   = n_hit + int'(hit_s[k]);
      n_wrong = n_wrong + int'(wrong_s[k]);
    end
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        score_d = '0;
        combo_d = '0;
        max_d   = '0;
        if (running) state_d = RUN;
      end
      RUN: begin
        if (!running) begin
          state_d = PAUSE;
        end else begin
          hit_d   = hit_s;
          miss_d  = miss_s;
          score_d = SCORE_W'(sat_add(int'(score_q),
                      n_hit - PENALTY * n_wrong, MAX_SCORE));
          if ((|miss_s) || (|wrong_s))
            combo_d = '0;
          else
            combo_d = SCORE_W'(sat_add(int'(combo_q), n_hit, CMAX));
          if (combo_d > max_q) max_d = combo_d;
          if (tick) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DEPTH - 1)) state_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (running) state_d = RUN;
      end
      DONE: begin
        if (!running) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign combo     = combo_q;
  assign max_combo = max_q;
  assign done      = (state_q == DONE);

endmodule
